// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
//
// Arbitrates the single scalar register-file writeback port among NUM_FU
// out-of-order functional units. Each cycle one eligible requester wins. The
// lowest-index requester whose wait counter has reached MAX_WAIT wins first.
// Otherwise the winner is chosen round-robin, starting at the RR pointer.
// The winner is registered into a one-entry writeback slot. Speculative
// requests and speculative slot contents are squashed on flush.
//
// Optional build macro: WB_ARB_STATS_EN
//   Adds stall_cycles_o, a saturating count of cycles with requests pending
//   and no grant. Also adds grant_cnt_o, one saturating 16-bit grant counter
//   per FU.
//
// Ports:
//   CLK_i        clock
//   nRST_i       synchronous active-low reset
//   fu_req_i     per-FU writeback request
//   fu_spec_i    per-FU result is speculative (unresolved branch)
//   fu_reg_i     per-FU destination register, FU i at [i*REG_W +: REG_W]
//   fu_data_i    per-FU result data, FU i at [i*DATA_W +: DATA_W]
//   fu_ack_o     one-hot combinational grant
//   flush_i      branch miss, squash speculative work
//   wb_ready_i   register file consumes the slot this cycle
//   wb_valid_o   slot holds a result
//   wb_reg_o     slot destination register
//   wb_data_o    slot data
//   wb_fu_o      index of the FU that produced the slot
//   stall_cycles_o / grant_cnt_o   (WB_ARB_STATS_EN only)
// -----------------------------------------------------------------------------
module wb_port_arbiter #(
    parameter int NUM_FU   = 5,
    parameter int DATA_W   = 32,
    parameter int REG_W    = 5,
    parameter int MAX_WAIT = 7
) (
    input  logic                     CLK_i,
    input  logic                     nRST_i,
    input  logic [NUM_FU-1:0]        fu_req_i,
    input  logic [NUM_FU-1:0]        fu_spec_i,
    input  logic [NUM_FU*REG_W-1:0]  fu_reg_i,
    input  logic [NUM_FU*DATA_W-1:0] fu_data_i,
    output logic [NUM_FU-1:0]        fu_ack_o,
    input  logic                     flush_i,
    input  logic                     wb_ready_i,
    output logic                     wb_valid_o,
    output logic [REG_W-1:0]         wb_reg_o,
    output logic [DATA_W-1:0]        wb_data_o,
    output logic [2:0]               wb_fu_o
`ifdef WB_ARB_STATS_EN
    ,
    output logic [15:0]              stall_cycles_o,
    output logic [NUM_FU*16-1:0]     grant_cnt_o
`endif
);

    localparam int            IDX_W    = 3;
    localparam logic [3:0]    WAIT_MAX = 4'(MAX_WAIT);
    localparam logic [IDX_W:0] NUM_FU_W = (IDX_W+1)'(NUM_FU);

    logic                wb_valid_q, wb_valid_d;
    logic                wb_spec_q,  wb_spec_d;
    logic [REG_W-1:0]    wb_reg_q,   wb_reg_d;
    logic [DATA_W-1:0]   wb_data_q,  wb_data_d;
    logic [IDX_W-1:0]    wb_fu_q,    wb_fu_d;
    logic [IDX_W-1:0]    ptr_q,      ptr_d;
    logic [3:0]          wait_q [NUM_FU];
    logic [3:0]          wait_d [NUM_FU];

    logic                slot_free;
    logic [NUM_FU-1:0]   elig;
    logic [2*NUM_FU-1:0] elig_dbl, elig_shift;
    logic [NUM_FU-1:0]   elig_rot;
    logic                force_hit;
    logic [IDX_W-1:0]    force_idx;
    logic [IDX_W-1:0]    rr_off, rr_idx;
    logic [IDX_W:0]      rr_sum;
    logic [IDX_W-1:0]    win_idx;
    logic                grant_en;
    logic [NUM_FU-1:0]   ack;
    logic [REG_W-1:0]    sel_reg;
    logic [DATA_W-1:0]   sel_data;
    logic                sel_spec;

    assign slot_free = !wb_valid_q || wb_ready_i;
    assign elig      = fu_req_i & ~({NUM_FU{flush_i}} & fu_spec_i);

    // Winner selection: forced priority first, then round-robin from ptr_q.
    always_comb begin
        force_hit = 1'b0;
        force_idx = '0;
        for (int i = NUM_FU-1; i >= 0; i--) begin
            if (elig[i] && wait_q[i] == WAIT_MAX) begin
                force_hit = 1'b1;
                force_idx = IDX_W'(i);
            end
        end

        // Rotate the eligible vector so that bit 0 is the FU at ptr_q.
        elig_dbl   = {elig, elig};
        elig_shift = elig_dbl >> ptr_q;
        elig_rot   = elig_shift[NUM_FU-1:0];
        rr_off     = '0;
        for (int k = NUM_FU-1; k >= 0; k--) begin
            if (elig_rot[k]) rr_off = IDX_W'(k);
        end
        rr_sum = {1'b0, ptr_q} + {1'b0, rr_off};
        rr_idx = (rr_sum >= NUM_FU_W) ? IDX_W'(rr_sum - NUM_FU_W) : IDX_W'(rr_sum);

        win_idx  = force_hit ? force_idx : rr_idx;
        // nRST_i gates the grant so that acks drop in the same cycle reset asserts.
        grant_en = nRST_i && slot_free && (|elig);
        ack      = grant_en ? (NUM_FU'(1) << win_idx) : '0;
    end

    assign fu_ack_o = ack;

    always_comb begin
        sel_reg  = '0;
        sel_data = '0;
        sel_spec = 1'b0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (win_idx == IDX_W'(i)) begin
                sel_reg  = fu_reg_i[i*REG_W +: REG_W];
                sel_data = fu_data_i[i*DATA_W +: DATA_W];
                sel_spec = fu_spec_i[i];
            end
        end
    end

    always_comb begin
        wb_valid_d = wb_valid_q;
        wb_spec_d  = wb_spec_q;
        wb_reg_d   = wb_reg_q;
        wb_data_d  = wb_data_q;
        wb_fu_d    = wb_fu_q;
        ptr_d      = ptr_q;
        if (grant_en) begin
            wb_valid_d = 1'b1;
            wb_spec_d  = sel_spec;
            wb_reg_d   = sel_reg;
            wb_data_d  = sel_data;
            wb_fu_d    = win_idx;
            ptr_d      = (win_idx == IDX_W'(NUM_FU-1)) ? '0 : win_idx + 1'b1;
        end else if (slot_free || (flush_i && wb_spec_q)) begin
            // The slot drained with no refill, or a stalled speculative slot is squashed.
            wb_valid_d = 1'b0;
            wb_spec_d  = 1'b0;
        end

        for (int i = 0; i < NUM_FU; i++) begin
            if (!fu_req_i[i] || ack[i] || (flush_i && fu_spec_i[i]))
                wait_d[i] = 4'd0;
            else if (wait_q[i] != WAIT_MAX)
                wait_d[i] = wait_q[i] + 4'd1;
            else
                wait_d[i] = wait_q[i];
        end
    end

    always_ff @(posedge CLK_i) begin
        if (!nRST_i) begin
            wb_valid_q <= 1'b0;
            wb_spec_q  <= 1'b0;
            wb_reg_q   <= '0;
            wb_data_q  <= '0;
            wb_fu_q    <= '0;
            ptr_q      <= '0;
            for (int i = 0; i < NUM_FU; i++) wait_q[i] <= 4'd0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_spec_q  <= wb_spec_d;
            wb_reg_q   <= wb_reg_d;
            wb_data_q  <= wb_data_d;
            wb_fu_q    <= wb_fu_d;
            ptr_q      <= ptr_d;
            for (int i = 0; i < NUM_FU; i++) wait_q[i] <= wait_d[i];
        end
    end

    assign wb_valid_o = wb_valid_q;
    assign wb_reg_o   = wb_reg_q;
    assign wb_data_o  = wb_data_q;
    assign wb_fu_o    = wb_fu_q;

`ifdef WB_ARB_STATS_EN
    logic [15:0] stall_q, stall_d;
    logic [15:0] gcnt_q [NUM_FU];
    logic [15:0] gcnt_d [NUM_FU];

    always_comb begin
        stall_d = stall_q;
        if ((|fu_req_i) && !grant_en && stall_q != 16'hFFFF)
            stall_d = stall_q + 16'd1;
        for (int i = 0; i < NUM_FU; i++) begin
            gcnt_d[i] = gcnt_q[i];
            if (ack[i] && gcnt_q[i] != 16'hFFFF)
                gcnt_d[i] = gcnt_q[i] + 16'd1;
        end
    end

    always_ff @(posedge CLK_i) begin
        if (!nRST_i) begin
            stall_q <= '0;
            for (int i = 0; i < NUM_FU; i++) gcnt_q[i] <= '0;
        end else begin
            stall_q <= stall_d;
            for (int i = 0; i < NUM_FU; i++) gcnt_q[i] <= gcnt_d[i];
        end
    end

    always_comb begin
        grant_cnt_o = '0;
        for (int i = 0; i < NUM_FU; i++) grant_cnt_o[i*16 +: 16] = gcnt_q[i];
    end

    assign stall_cycles_o = stall_q;
`endif

endmodule
